// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary neuron datapath: weight codes, FSM states
// and the accumulator width rule.
package tnn_pkg;

    localparam logic [1:0] W_POS = 2'b01;
    localparam logic [1:0] W_NEG = 2'b11;

    typedef enum logic {
        ST_ACC,
        ST_OUT
    } tnn_state_e;

    // Enough headroom for N_IN terms of magnitude 2**in_w - 1, plus a sign bit.
    function automatic int acc_width(input int in_w, input int n_in);
        return in_w + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/tnn_lane_mac.sv
// Combinational ternary multiply-and-add of one input beat (LANES activations),
// with optional LSB masking of each activation.
module tnn_lane_mac
    import tnn_pkg::*;
#(
    parameter int IN_W  = 3,
    parameter int LANES = 2,
    parameter int DROP  = 1,
    parameter int ACC_W = 7
)(
    input  logic [LANES*IN_W-1:0]   i_data,
    input  logic [2*LANES-1:0]      i_weights,
    input  logic                    i_approx,
    output logic signed [ACC_W-1:0] o_sum
);

    logic [IN_W-1:0]         w_mask;
    logic [IN_W-1:0]         w_act;
    logic signed [ACC_W-1:0] w_term;

    assign w_mask = i_approx ? ({IN_W{1'b1}} << DROP) : '1;

    always_comb begin
        o_sum  = '0;
        w_act  = '0;
        w_term = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_act  = i_data[l*IN_W +: IN_W] & w_mask;
            w_term = signed'(ACC_W'(w_act));
            case (i_weights[2*l +: 2])
                W_POS:   o_sum = o_sum + w_term;
                W_NEG:   o_sum = o_sum - w_term;
                default: o_sum = o_sum;
            endcase
        end
    end

endmodule

// File: rtl/tnn_neuron_stream.sv
// Streaming ternary-weight neuron: accumulates N_IN activations over
// N_IN/LANES beats, then presents the signed sum and its threshold decision.
module tnn_neuron_stream
    import tnn_pkg::*;
#(
    parameter  int IN_W  = 3,
    parameter  int N_IN  = 6,
    parameter  int LANES = 2,
    parameter  int DROP  = 1,
    localparam int ACC_W = acc_width(IN_W, N_IN)
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*IN_W-1:0]   in_data,
    input  logic                    in_last,
    input  logic [2*N_IN-1:0]       weights,
    input  logic signed [ACC_W-1:0] thr,
    input  logic                    approx_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
    output logic signed [ACC_W-1:0] out_sum,
    output logic                    err
);

    localparam int              NBEATS   = N_IN / LANES;
    localparam int              CNT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

    tnn_state_e              r_state;
    tnn_state_e              w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_thr_q;
    logic signed [ACC_W-1:0] r_out_sum;
    logic [2*N_IN-1:0]       r_weights_q;
    logic                    r_approx_q;
    logic                    r_out_bit;
    logic                    r_err;

    logic                    w_in_ready;
    logic                    w_out_valid;
    logic                    w_accept;
    logic                    w_first;
    logic                    w_final;
    logic                    w_approx;
    logic [2*N_IN-1:0]       w_weights;
    logic [2*LANES-1:0]      w_beat_w;
    logic signed [ACC_W-1:0] w_thr;
    logic signed [ACC_W-1:0] w_beat_sum;
    logic signed [ACC_W-1:0] w_new_acc;

    // The first beat of a frame uses the live configuration; later beats use the captured copy.
    assign w_first   = (r_cnt == '0);
    assign w_final   = (r_cnt == LAST_CNT);
    assign w_accept  = in_valid && w_in_ready;
    assign w_weights = w_first ? weights   : r_weights_q;
    assign w_thr     = w_first ? thr       : r_thr_q;
    assign w_approx  = w_first ? approx_en : r_approx_q;
    assign w_beat_w  = w_weights[r_cnt*2*LANES +: 2*LANES];
    assign w_new_acc = r_acc + w_beat_sum;

    tnn_lane_mac #(
        .IN_W  (IN_W),
        .LANES (LANES),
        .DROP  (DROP),
        .ACC_W (ACC_W)
    ) u_lane_mac (
        .i_data    (in_data),
        .i_weights (w_beat_w),
        .i_approx  (w_approx),
        .o_sum     (w_beat_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_in_ready = rst_n;
                if (in_valid && rst_n && w_final) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_ACC;
                end
            end
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_weights_q <= '0;
            r_thr_q     <= '0;
            r_approx_q  <= 1'b0;
            r_out_sum   <= '0;
            r_out_bit   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_err <= w_accept && (in_last != w_final);
            if (w_accept) begin
                if (w_first) begin
                    r_weights_q <= weights;
                    r_thr_q     <= thr;
                    r_approx_q  <= approx_en;
                end
                // Decision is registered with the sum so it is valid even when N_IN == LANES.
                if (w_final) begin
                    r_out_sum <= w_new_acc;
                    r_out_bit <= (w_new_acc >= w_thr);
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_new_acc;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_bit   = r_out_bit;
    assign out_sum   = r_out_sum;
    assign err       = r_err;

endmodule

// File: tb/tb_tnn_neuron_stream.sv
// Directed scoreboard bench for tnn_neuron_stream with default parameters.
module tb_tnn_neuron_stream;

    localparam int IN_W  = 3;
    localparam int N_IN  = 6;
    localparam int LANES = 2;
    localparam int DROP  = 1;
    localparam int ACC_W = 7;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*IN_W-1:0]   in_data;
    logic                    in_last;
    logic [2*N_IN-1:0]       weights;
    logic signed [ACC_W-1:0] thr;
    logic                    approx_en;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_bit;
    logic signed [ACC_W-1:0] out_sum;
    logic                    err;

    int     exp_sum_q[$];
    logic   exp_bit_q[$];
    int     n_checks   = 0;
    int     n_fail     = 0;
    int     err_pulses = 0;
    int     mon_sum;
    logic   mon_bit;
    logic   e_s;
    logic   ov_s;

    always #5 clk = ~clk;

    tnn_neuron_stream #(
        .IN_W  (IN_W),
        .N_IN  (N_IN),
        .LANES (LANES),
        .DROP  (DROP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .weights   (weights),
        .thr       (thr),
        .approx_en (approx_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_sum   (out_sum),
        .err       (err)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [N_IN*IN_W-1:0] pk_a(input int a[6]);
        logic [N_IN*IN_W-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[i*IN_W +: IN_W] = IN_W'(a[i]);
        return r;
    endfunction

    function automatic logic [2*N_IN-1:0] pk_w(input int w[6]);
        logic [2*N_IN-1:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (w[i] == 1)       r[2*i +: 2] = 2'b01;
            else if (w[i] == -1) r[2*i +: 2] = 2'b11;
            else                 r[2*i +: 2] = 2'b00;
        end
        return r;
    endfunction

    // Monitor: every output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_sum_q.size() == 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                mon_sum = exp_sum_q.pop_front();
                mon_bit = exp_bit_q.pop_front();
                check("sb_out_sum", out_sum, mon_sum);
                check("sb_out_bit", out_bit, mon_bit);
            end
        end
    end

    always @(negedge clk) begin
        if (err === 1'b1) err_pulses++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int s, input logic b);
        exp_sum_q.push_back(s);
        exp_bit_q.push_back(b);
    endtask

    task automatic send_beat(input logic [LANES*IN_W-1:0] d, input logic last,
                             output logic e, output logic ov);
        int waited;
        bit got;
        waited = 0;
        got    = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!got && waited < 50) begin
            @(negedge clk);
            if (in_ready) got = 1;
            else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (!got) check("beat_handshake_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        e  = err;
        ov = out_valid;
    endtask

    task automatic send_frame(input logic [N_IN*IN_W-1:0] acts, input logic [2*N_IN-1:0] w,
                              input int t, input logic ap, input int es, input logic eb,
                              input string tag);
        logic e, ov;
        weights   = w;
        thr       = ACC_W'(t);
        approx_en = ap;
        push_exp(es, eb);
        for (int b = 0; b < 3; b++) begin
            send_beat(acts[b*LANES*IN_W +: LANES*IN_W], (b == 2), e, ov);
            check({tag, "_err"}, e, 0);
            check({tag, "_out_valid"}, ov, (b == 2) ? 1 : 0);
        end
    endtask

    initial begin
        logic [N_IN*IN_W-1:0] acts;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        weights   = '0;
        thr       = '0;
        approx_en = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_in_ready", in_ready, 1);

        // Full-scale sum at and just above the threshold.
        send_frame(pk_a('{7,7,7,7,7,7}), pk_w('{1,1,1,1,1,1}), 42, 1'b0, 42, 1'b1, "max_thr42");
        send_frame(pk_a('{7,7,7,7,7,7}), pk_w('{1,1,1,1,1,1}), 43, 1'b0, 42, 1'b0, "max_thr43");

        // Mixed signs, then an all-negative sum.
        send_frame(pk_a('{7,3,5,1,6,2}), pk_w('{1,-1,1,-1,0,-1}), 7, 1'b0, 6, 1'b0, "mixed");
        send_frame(pk_a('{1,1,1,1,1,1}), pk_w('{-1,-1,-1,-1,-1,-1}), -10, 1'b0, -6, 1'b1, "neg");

        // Approximation drops the LSB: 3 -> 2.
        send_frame(pk_a('{3,3,3,3,3,3}), pk_w('{1,1,1,1,1,1}), 0, 1'b1, 12, 1'b1, "approx");

        // Configuration changes after the first beat must be ignored.
        acts      = pk_a('{3,3,3,3,3,3});
        weights   = pk_w('{1,1,1,1,1,1});
        thr       = ACC_W'(0);
        approx_en = 1'b1;
        push_exp(12, 1'b1);
        send_beat(acts[0 +: 6], 1'b0, e_s, ov_s);
        check("cfg_hold_err0", e_s, 0);
        approx_en = 1'b0;
        weights   = '0;
        thr       = ACC_W'(63);
        send_beat(acts[6 +: 6], 1'b0, e_s, ov_s);
        check("cfg_hold_err1", e_s, 0);
        send_beat(acts[12 +: 6], 1'b1, e_s, ov_s);
        check("cfg_hold_out_valid", ov_s, 1);

        // Output back-pressure.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_frame(pk_a('{7,7,7,7,7,7}), pk_w('{1,1,1,1,1,1}), 42, 1'b0, 42, 1'b1, "stall");
        repeat (5) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_sum", out_sum, 42);
            check("stall_out_bit", out_bit, 1);
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_release_in_ready", in_ready, 1);
        check("stall_release_out_valid", out_valid, 0);

        // in_last early on beat 2, missing on beat 3.
        acts    = pk_a('{1,1,1,1,1,1});
        weights = pk_w('{1,1,1,1,1,1});
        thr     = ACC_W'(6);
        approx_en = 1'b0;
        push_exp(6, 1'b1);
        send_beat(acts[0 +: 6], 1'b0, e_s, ov_s);
        check("last_err_beat1", e_s, 0);
        send_beat(acts[6 +: 6], 1'b1, e_s, ov_s);
        check("last_err_beat2", e_s, 1);
        check("last_no_early_result", ov_s, 0);
        send_beat(acts[12 +: 6], 1'b0, e_s, ov_s);
        check("last_err_beat3", e_s, 1);
        check("last_result_valid", ov_s, 1);

        // Reset mid-frame discards the partial sum.
        acts    = pk_a('{7,7,7,7,7,7});
        weights = pk_w('{1,1,1,1,1,1});
        send_beat(acts[0 +: 6], 1'b0, e_s, ov_s);
        send_beat(acts[6 +: 6], 1'b0, e_s, ov_s);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_out_bit", out_bit, 0);
        check("midrst_err", err, 0);
        check("midrst_in_ready", in_ready, 1);
        send_frame(pk_a('{1,1,1,1,1,1}), pk_w('{1,1,1,1,1,1}), 0, 1'b0, 6, 1'b1, "post_rst");

        repeat (3) @(negedge clk);
        check("sb_drained", exp_sum_q.size(), 0);
        check("err_pulse_total", err_pulses, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tnn_neuron_stream.md
# tnn_neuron_stream

Streaming, parametrised ternary-weight neuron for the TNN accelerator datapath. It accepts N_IN unsigned activations of IN_W bits, LANES per beat, over a valid/ready stream. It forms the ternary-weighted sum, optionally with LSB-dropping approximation, and emits a one-bit threshold decision plus the exact sum. It generalises the fixed six-input, three-bit combinational approximate neurons to arbitrary fan-in, width and lane count, and adds a registered pipeline, back-pressure and a runtime approximation mode.

## Interface
- IN_W, 3, activation width (unsigned)
- N_IN, 6, neuron fan-in; must be a multiple of LANES
- LANES, 2, activations per input beat
- DROP, 1, LSBs zeroed per activation when approximation is enabled; 0 ≤ DROP < IN_W
- ACC_W, IN_W+$clog2(N_IN)+1, signed accumulator width (derived, not overridden)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*IN_W  lane l in bits [l*IN_W +: IN_W]
- in_last  in  1  producer's end-of-frame marker
- weights  in  2*N_IN  ternary weight i in bits [2i+:2]: 01=+1, 11=−1, 00/10=0
- thr  in  ACC_W  signed threshold
- approx_en  in  1  enable LSB dropping
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_bit  out  1  sum ≥ thr (signed)
- out_sum  out  ACC_W  signed weighted sum
- err  out  1  one-cycle pulse on frame-length mismatch

## Operation
- States: ACC and OUT. Reset state is ACC with beat counter cnt=0 and acc=0.
- ACC: in_ready=1. A beat is accepted when in_valid&&in_ready.
  - Activation index for lane l of beat cnt is i=cnt*LANES+l.
  - Term = a_i·w_i, where a_i is in_data lane l with its low DROP bits zeroed if approx_en_q.
  - acc += sum of the LANES terms. All terms are signed ACC_W, so no overflow is possible.
- On the first beat (cnt=0), weights, thr and approx_en are registered into weights_q, thr_q and approx_en_q. The first beat itself already uses the live values. Changes mid-frame are ignored.
- Final beat is cnt=N_IN/LANES−1. On it: out_sum←acc+terms, acc←0, cnt←0, go to OUT.
- in_last is checked against the counter only. err pulses in the cycle after any accepted beat where in_last ≠ (beat is final). The frame still closes on the counter.
- OUT: in_ready=0, out_valid=1. out_bit=($signed(out_sum) ≥ $signed(thr_q)). out_sum and out_bit stay stable until out_valid&&out_ready, then the block returns to ACC.
- Reset mid-frame discards the partial sum and any pending result.

## Timing
- Reset values:
  - in_ready=0 while rst_n=0, 1 the cycle after release.
  - out_valid=0, out_bit=0, out_sum=0, err=0, cnt=0, acc=0.
- Frame latency: out_valid rises the cycle after the final-beat handshake.
- Throughput: N_IN/LANES+1 cycles per frame with out_ready held high. There is one bubble cycle in OUT and no input/output overlap.
- Output back-pressure stalls input: in_ready stays 0 for as long as out_ready stays low.
- in_valid gaps mid-frame only pause cnt; there is no timeout.
- N_IN=LANES is legal: every beat is final, and the weights are registered on that same beat.

## Structure
- Shared package tnn_pkg holds:
  - the ternary weight encoding constants (W_POS=2'b01, W_NEG=2'b11);
  - the state enum typedef;
  - the function clog2-based acc_width(in_w,n_in).
- One sub-module, tnn_lane_mac: combinational LANES-way ternary multiply-and-add of a beat, with approx LSB masking. It is instantiated once. The FSM, counter, capture registers and comparator live in the top.

## Test plan
All scenarios use defaults (N_IN=6, LANES=2, IN_W=3, DROP=1).
- All activations 7, all weights +1, thr=42 → out_sum=42, out_bit=1. Repeat with thr=43 → out_bit=0. out_valid rises exactly 1 cycle after beat 3.
- Activations 7,3,5,1,6,2 with weights +1,−1,+1,−1,0,−1 → out_sum=6. Negative case: thr=7 → out_bit=0. Weights all −1 with thr=−10 and activations all 1 → out_sum=−6, out_bit=1.
- approx_en=1, all activations 3, weights +1 → out_sum=12. approx_en toggled to 0 after beat 1 → still 12.
- Hold out_ready=0 for 5 cycles → out_valid, out_sum and out_bit stable, in_ready=0 throughout. Release → handshake, then in_ready=1 next cycle.
- in_last on beat 2 of 3 → err pulse after beat 2, a second err after beat 3 (last missing), and the result is still produced after beat 3.
- rst_n low for 1 cycle after 2 beats → all outputs at reset values. The next full frame of all 1s with weights +1 gives out_sum=6.
